// File: rtl/normalizer_pkg.sv
// Shared types and helpers for the normalizer and its companion shifter.
package normalizer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Bits needed to hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    for (int w = 0; w < 32; w++)
      if ((64'd1 << w) >= 64'(n + 1)) return w;
    return 32;
  endfunction

endpackage

// File: rtl/normalizer.sv
// Iterative normaliser: shifts one bit per cycle until a 1 reaches the
// target end and reports the number of shifts (leading/trailing zero count).
module normalizer
  import normalizer_pkg::*;
#(
  parameter int N = 8,
  parameter int W = cnt_width(N)
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_start,
  input  logic         i_direction,
  input  logic [N-1:0] i_value,
  output logic         o_busy,
  output logic         o_finished,
  output logic [N-1:0] o_value,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  state_e       state_q, state_d;
  logic [N-1:0] value_q;
  logic [W-1:0] count_q;
  logic         zero_q;
  logic         dir_q;
  logic         target;
  logic         in_zero;
  logic         accept;

  assign in_zero = (i_value == '0);
  assign accept  = (state_q == ST_IDLE) && i_start;
  assign target  = (dir_q == DIR_LEFT) ? value_q[N-1] : value_q[0];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_start) state_d = in_zero ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (target)  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state_q == ST_SHIFT);
    o_finished = (state_q == ST_DONE);
  end

  // A zero operand short-circuits straight to DONE with the full-width count.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      value_q <= '0;
      count_q <= '0;
      zero_q  <= 1'b0;
      dir_q   <= DIR_RIGHT;
    end else if (accept) begin
      value_q <= i_value;
      count_q <= in_zero ? W'(N) : '0;
      zero_q  <= in_zero;
      dir_q   <= i_direction;
    end else if (state_q == ST_SHIFT && !target) begin
      value_q <= (dir_q == DIR_LEFT) ? (value_q << 1) : (value_q >> 1);
      count_q <= count_q + W'(1);
    end
  end

  assign o_value = value_q;
  assign o_count = count_q;
  assign o_zero  = zero_q;

endmodule

// File: tb/tb_normalizer.sv
// Scoreboard bench for normalizer: driver pushes model results, monitor
// pops and compares on every o_finished pulse, including its cycle of arrival.
module tb_normalizer;

  localparam int N = 8;
  localparam int W = 4;

  logic         i_clock = 1'b0;
  logic         i_reset_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_direction = 1'b0;
  logic [N-1:0] i_value = '0;
  logic         o_busy, o_finished, o_zero;
  logic [N-1:0] o_value;
  logic [W-1:0] o_count;

  normalizer #(.N(N), .W(W)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n), .i_start(i_start),
    .i_direction(i_direction), .i_value(i_value), .o_busy(o_busy),
    .o_finished(o_finished), .o_value(o_value), .o_count(o_count),
    .o_zero(o_zero)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [N-1:0] val;
    logic [W-1:0] cnt;
    logic         zero;
    int           done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: count zeros from the target end, then shift by that amount.
  function automatic exp_t model(input logic [N-1:0] v, input logic dir, input int start_cyc);
    exp_t e;
    int k = 0;
    if (v == 0) begin
      e.val = '0; e.cnt = W'(N); e.zero = 1'b1; e.done_cyc = start_cyc;
    end else begin
      if (dir) while (v[N-1-k] == 1'b0) k++;
      else     while (v[k] == 1'b0) k++;
      e.val = dir ? (v << k) : (v >> k);
      e.cnt = W'(k); e.zero = 1'b0; e.done_cyc = start_cyc + k + 1;
    end
    return e;
  endfunction

  always @(negedge i_clock) begin
    if (i_reset_n && o_finished) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_finished: got pulse expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("value",   o_value, e.val);
        check("count",   o_count, e.cnt);
        check("zero",    o_zero, e.zero);
        check("latency", cyc, e.done_cyc);
        check("busy_in_done", o_busy, 0);
      end
    end
  end

  // Issue one start from just after a negedge; returns #1 after the start edge.
  task automatic op(input logic [N-1:0] v, input logic dir, input bit push);
    int s;
    i_start = 1'b1; i_value = v; i_direction = dir;
    s = cyc + 1;
    if (push) exp_q.push_back(model(v, dir, s));
    @(posedge i_clock); #1;
    i_start = 1'b0;
    i_value = N'($urandom);
    i_direction = 1'($urandom);
    check("busy_after_start", o_busy, (v != 0));
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 4 * N + 8; i++) begin
      @(negedge i_clock); #1;
      if (exp_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge i_clock);
  endtask

  task automatic run(input logic [N-1:0] v, input logic dir);
    op(v, dir, 1);
    wait_done();
  endtask

  initial begin
    logic [N-1:0] v;
    int s;
    #2;
    check("rst_value", o_value, 0);
    check("rst_count", o_count, 0);
    check("rst_zero", o_zero, 0);
    check("rst_busy", o_busy, 0);
    check("rst_finished", o_finished, 0);
    repeat (3) @(negedge i_clock);
    i_reset_n = 1'b1;
    @(negedge i_clock);

    run(8'h13, 1'b1);
    run(8'h28, 1'b0);
    run(8'h80, 1'b1);
    run(8'h01, 1'b0);
    run(8'h00, 1'b1);
    run(8'h00, 1'b0);
    run(8'h01, 1'b1);
    run(8'h80, 1'b0);

    // Start pulsed again mid-operation must be ignored.
    op(8'h01, 1'b1, 1);
    @(negedge i_clock);
    i_start = 1'b1; i_value = 8'hFF; i_direction = 1'b0;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    wait_done();

    // Start held high: operations every 4 edges, one idle cycle between.
    i_start = 1'b1; i_value = 8'h40; i_direction = 1'b1;
    s = cyc + 1;
    for (int j = 0; j < 3; j++) exp_q.push_back(model(8'h40, 1'b1, s + 4 * j));
    wait_done();
    i_start = 1'b0;
    repeat (3) @(negedge i_clock);
    check("held_start_drained", exp_q.size(), 0);

    for (int j = 0; j < 40; j++) begin
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = N'(1) << $urandom_range(0, N - 1);
        default: v = N'($urandom);
      endcase
      run(v, 1'($urandom));
    end

    // Asynchronous reset mid-shift: outputs clear with no clock edge.
    op(8'h01, 1'b1, 0);
    @(posedge i_clock); #3;
    i_reset_n = 1'b0;
    #1;
    check("async_value", o_value, 0);
    check("async_count", o_count, 0);
    check("async_zero", o_zero, 0);
    check("async_busy", o_busy, 0);
    check("async_finished", o_finished, 0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
    repeat (12) @(negedge i_clock);
    check("post_reset_busy", o_busy, 0);

    run(8'h13, 1'b1);
    run(8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/normalizer.md
Name: normalizer

Overview:
- Inverse companion to the iterative shifter. The shifter applies a known shift count; this block recovers the count.
- Takes a value and shifts it one bit per cycle until a 1 reaches the target end (MSB for left, LSB for right).
- Reports the normalised value and the number of shifts taken (leading-zero or trailing-zero count).
- Uses the same start/finished handshake as the shifter, so both blocks plug into the same control sequencer.

Parameters:
- N, 8, data width in bits (N >= 2).
- W, $clog2(N+1), width of the count output; holds 0..N.

Ports:
- i_clock  input  1  sole clock; all state changes on the rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_start  input  1  request; sampled only in IDLE.
- i_direction  input  1  1 = normalise to MSB (left shift, count leading zeros); 0 = normalise to LSB (right shift, count trailing zeros). Sampled with i_start.
- i_value  input  N  operand; sampled with i_start.
- o_busy  output  1  high in LOAD-accepted SHIFT state.
- o_finished  output  1  one-cycle pulse; high exactly while in DONE.
- o_value  output  N  normalised value; holds until the next accepted start.
- o_count  output  W  shifts performed (N if the operand is zero); holds until the next accepted start.
- o_zero  output  1  operand was zero; holds until the next accepted start.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low.
  - Reset asserted, at any time including mid-operation: state = IDLE, o_value = 0, o_count = 0, o_zero = 0, o_busy = 0, o_finished = 0, latched direction = 0. Takes effect immediately, not on the next edge.
  - After release, the first action occurs no earlier than the next rising edge.
- States: IDLE, SHIFT, DONE. Encoding is a shared package enum.
- IDLE:
  - On an edge with i_start = 1: load value = i_value, count = 0, dir = i_direction.
  - If i_value == 0: set o_zero = 1, count = N, value = 0, go to DONE.
  - Otherwise: set o_zero = 0 and go to SHIFT.
- SHIFT, on each edge:
  - Target bit is value[N-1] if dir = 1, value[0] if dir = 0.
  - Target bit = 1: go to DONE with value and count unchanged.
  - Target bit = 0: shift one place toward the target (zero fill), count = count + 1, stay in SHIFT.
  - Count cannot exceed N-1 here, because the operand is non-zero.
- DONE: o_finished = 1 for exactly one cycle, then return to IDLE on the next edge unconditionally.
- Latency:
  - For a non-zero operand with k zeros at the target end: start edge E0, shifts on E1..Ek, DONE entered at E(k+1), o_finished high for the cycle after E(k+1).
  - Zero operand: DONE entered at E0.
  - Maximum is N edges from start to the finished pulse.
- i_start in SHIFT or DONE is ignored, with no queuing. A start held high through DONE is accepted on the first edge after return to IDLE.
- i_value and i_direction changes after the start edge have no effect on the operation in progress.
- o_value and o_count update while shifting, so intermediate values are visible. They are valid only while o_finished = 1 and afterwards until the next accepted start.

Decomposition:
- Shared package contains:
  - state enum (IDLE/SHIFT/DONE);
  - direction constants DIR_LEFT = 1 and DIR_RIGHT = 0, also shared with the shifter;
  - a count-width function equivalent to $clog2(N+1).
- No sub-module: the datapath is one shift register, one W-bit counter and a 3-state FSM in a single module.

Test Plan:
- Reset: drive i_reset_n low during SHIFT with 0x01, left -> all outputs 0 within the same cycle, no clock edge needed; state IDLE; no o_finished pulse after release.
- N=8, left, i_value=0x13 -> o_value=0x98, o_count=3, o_zero=0; o_finished high for exactly 1 cycle after the 4th edge following the start edge.
- N=8, right, i_value=0x28 -> o_value=0x05, o_count=3; left with i_value=0x80 -> o_count=0, o_finished after edge E1.
- N=8, i_value=0x00, either direction -> o_zero=1, o_count=8, o_value=0x00, o_finished in the cycle after the start edge.
- Left, i_value=0x01; pulse i_start=1 with i_value=0xFF at E2 -> ignored; result o_value=0x80, o_count=7.
- i_start held high continuously with 0x40, left -> back-to-back operations, each giving o_count=1, one o_finished pulse per operation, IDLE for one cycle between operations.
